// File: rtl/m84_sample_reader_if.sv
// ============================================================================
// Module      : m84_sample_reader_if
// Description : Sample-ROM req/ack read port between the sample reader and
//               the external memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface m84_sample_reader_if;
    logic [24:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;

    modport master (
        output rom_addr,
        output rom_req,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  rom_req,
        output rom_ack,
        output rom_data
    );
endinterface

`default_nettype wire

// File: rtl/m84_sample_reader.sv
// ============================================================================
// Module      : m84_sample_reader
// Description : Z80 sample-port consumer: tracks the CPU sample address,
//               fetches the addressed ROM byte and drives the playback DAC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m84_sample_reader #(
    parameter logic [24:0] ROM_BASE = 25'h0
) (
    input  wire logic                CLK_32M,
    input  wire logic                reset,
    input  wire logic [15:0]         sample_addr,
    input  wire logic [1:0]          sample_addr_wr,
    input  wire logic                sample_inc,
    input  wire logic [7:0]          sample_out,
    output      logic [7:0]          sample_in,
    output      logic                sample_valid,
    output      logic signed [15:0]  dac_out,
    m84_sample_reader_if.master      rom
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_cur_addr;
    logic        r_pending;

    logic [15:0] w_wr_addr;
    logic [15:0] w_next_addr;
    logic        w_touch;
    logic [24:0] w_rom_addr;

    // Byte writes land first; a same-cycle increment then applies on top.
    always_comb begin
        w_wr_addr = r_cur_addr;
        if (sample_addr_wr[0]) w_wr_addr[7:0]  = sample_addr[7:0];
        if (sample_addr_wr[1]) w_wr_addr[15:8] = sample_addr[15:8];
        w_next_addr = w_wr_addr + {15'd0, sample_inc};
    end

    assign w_touch    = sample_inc | (|sample_addr_wr);
    assign w_rom_addr = ROM_BASE + {9'd0, r_cur_addr};

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= 16'h0000;
            r_pending    <= 1'b0;
            sample_in    <= 8'hFF;
            sample_valid <= 1'b0;
            dac_out      <= 16'sh0000;
            rom.rom_addr <= ROM_BASE;
            rom.rom_req  <= 1'b0;
        end else begin
            r_cur_addr <= w_next_addr;

            if (sample_inc) begin
                dac_out <= {sample_out ^ 8'h80, 8'h00};
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        rom.rom_addr <= w_rom_addr;
                        rom.rom_req  <= 1'b1;
                        r_pending    <= 1'b0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A request in flight is always completed; data returned
                    // for an address that has since moved is dropped.
                    if (rom.rom_ack) begin
                        rom.rom_req <= 1'b0;
                        r_state     <= S_IDLE;
                        if (!r_pending) begin
                            sample_in    <= rom.rom_data;
                            sample_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Placed last so an address change overrides any completion above.
            if (w_touch) begin
                r_pending    <= 1'b1;
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m84_sample_reader.sv
// ============================================================================
// Module      : tb_m84_sample_reader
// Description : Self-checking bench for m84_sample_reader with a ROM responder
//               and a behavioural address/DAC model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_m84_sample_reader;

    localparam logic [24:0] BASE = 25'h1FF_8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_addr = 16'h0;
    logic [1:0]  sample_addr_wr = 2'b00;
    logic        sample_inc = 1'b0;
    logic [7:0]  sample_out = 8'h0;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic [15:0] dac_out;

    logic        resp_ack = 1'b0;
    logic [7:0]  resp_data = 8'h0;
    logic        man_ack = 1'b0;
    logic [7:0]  man_data = 8'h0;

    logic        resp_en = 1'b0;
    logic        rand_delay = 1'b0;
    int          fixed_delay = 5;
    logic        mon_en = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;

    logic [15:0] model_addr = 16'h0;
    logic [15:0] model_dac = 16'h0;
    int          touch_cnt = 0;
    logic [24:0] req_q[$];

    always #5 clk = ~clk;

    m84_sample_reader_if bus();
    assign bus.rom_ack  = resp_ack | man_ack;
    assign bus.rom_data = man_ack ? man_data : resp_data;

    m84_sample_reader #(.ROM_BASE(BASE)) dut (
        .CLK_32M        (clk),
        .reset          (reset),
        .sample_addr    (sample_addr),
        .sample_addr_wr (sample_addr_wr),
        .sample_inc     (sample_inc),
        .sample_out     (sample_out),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .dac_out        (dac_out),
        .rom            (bus)
    );

    function automatic logic [7:0] mem(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]} ^ 8'h3C;
    endfunction

    function automatic logic [24:0] rom_of(input logic [15:0] a);
        return BASE + {9'd0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] wr, input logic [15:0] a,
                         input logic inc, input logic [7:0] so);
        sample_addr_wr = wr;
        sample_addr    = a;
        sample_inc     = inc;
        sample_out     = so;
        @(posedge clk);
        if (wr[0]) model_addr[7:0]  = a[7:0];
        if (wr[1]) model_addr[15:8] = a[15:8];
        model_addr = model_addr + 16'(inc);
        if (inc) model_dac = 16'((int'(so) - 128) * 256);
        if (wr != 2'b00 || inc) touch_cnt++;
        #1;
        sample_addr_wr = 2'b00;
        sample_inc     = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!sample_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, {31'd0, sample_valid}, 32'd1);
    endtask

    // ROM responder: acks each request after a fixed or random delay.
    initial begin
        int d;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && bus.rom_req) begin
                d = rand_delay ? int'($urandom_range(0, 6)) : fixed_delay;
                repeat (d) begin
                    @(posedge clk);
                    #1;
                end
                if (bus.rom_req && resp_en) begin
                    resp_ack  = 1'b1;
                    resp_data = mem(bus.rom_addr);
                    @(posedge clk);
                    #1;
                    resp_ack  = 1'b0;
                end
            end
        end
    end

    // Protocol and model invariants, sampled mid-cycle.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [24:0] prev_addr = 25'h0;
    int          seen_touch = 0;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (prev_req && !prev_ack) begin
                check("req_hold", {31'd0, bus.rom_req}, 32'd1);
                check("addr_hold", {7'd0, bus.rom_addr}, {7'd0, prev_addr});
            end
            if (prev_req && prev_ack) begin
                check("req_gap", {31'd0, bus.rom_req}, 32'd0);
            end
            if (bus.rom_req && !prev_req) req_q.push_back(bus.rom_addr);
            if (touch_cnt != seen_touch) begin
                check("valid_clear", {31'd0, sample_valid}, 32'd0);
                seen_touch = touch_cnt;
            end
            if (sample_valid) begin
                check("sin_model", {24'd0, sample_in}, {24'd0, mem(rom_of(model_addr))});
            end
            check("dac_model", {16'd0, dac_out}, {16'd0, model_dac});
        end
        prev_req  = bus.rom_req;
        prev_ack  = bus.rom_ack;
        prev_addr = bus.rom_addr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, expected normal end");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  wr;
        logic [15:0] a;
        logic        inc;
        logic [7:0]  so;
        logic [15:0] exp_addr;
        logic [15:0] exp_dac;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n0;
        int k;

        vt[0] = '{2'b11, 16'hBEEF, 1'b1, 8'h80, 16'hBEF0, 16'h0000};
        vt[1] = '{2'b01, 16'h0034, 1'b0, 8'h00, 16'hBE34, 16'h0000};
        vt[2] = '{2'b10, 16'h1200, 1'b0, 8'h00, 16'h1234, 16'h0000};
        vt[3] = '{2'b00, 16'h0000, 1'b1, 8'hFF, 16'h1235, 16'h7F00};
        vt[4] = '{2'b11, 16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 16'h7F00};
        vt[5] = '{2'b00, 16'h0000, 1'b1, 8'h00, 16'h0000, 16'h8000};
        vt[6] = '{2'b01, 16'h00FF, 1'b1, 8'h01, 16'h0100, 16'h8100};
        vt[7] = '{2'b10, 16'hFF00, 1'b1, 8'h7F, 16'hFF01, 16'hFF00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample_in", {24'd0, sample_in}, 32'hFF);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_req", {31'd0, bus.rom_req}, 32'd0);
        check("rst_rom_addr", {7'd0, bus.rom_addr}, {7'd0, BASE});
        check("rst_dac", {16'd0, dac_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("idle_no_req", {31'd0, bus.rom_req}, 32'd0);
            idle(1);
        end
        mon_en  = 1'b1;
        resp_en = 1'b1;

        // Split low/high write: first fetch goes stale, second one lands
        fixed_delay = 5;
        n0 = req_q.size();
        drive(2'b01, 16'h0034, 1'b0, 8'h00);
        drive(2'b10, 16'h1200, 1'b0, 8'h00);
        wait_valid("split_valid");
        check("split_sin", {24'd0, sample_in}, {24'd0, mem(rom_of(16'h1234))});
        check("split_req_cnt", req_q.size() - n0, 32'd2);
        if (req_q.size() >= n0 + 2) begin
            check("split_first", {7'd0, req_q[n0]}, {7'd0, rom_of(16'h0034)});
            check("split_second", {7'd0, req_q[n0 + 1]}, {7'd0, rom_of(16'h1234)});
        end
        check("split_rom_addr", {7'd0, bus.rom_addr}, {7'd0, rom_of(16'h1234)});

        // Address/DAC vector table
        fixed_delay = 2;
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].wr, vt[i].a, vt[i].inc, vt[i].so);
            wait_valid($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_addr", i), {7'd0, bus.rom_addr}, {7'd0, rom_of(vt[i].exp_addr)});
            check($sformatf("vec%0d_sin", i), {24'd0, sample_in}, {24'd0, mem(rom_of(vt[i].exp_addr))});
            check($sformatf("vec%0d_dac", i), {16'd0, dac_out}, {16'd0, vt[i].exp_dac});
        end

        // Three increments around a single slow request
        fixed_delay = 8;
        n0 = req_q.size();
        drive(2'b00, 16'h0, 1'b1, 8'h10);
        idle(2);
        drive(2'b00, 16'h0, 1'b1, 8'h20);
        idle(1);
        drive(2'b00, 16'h0, 1'b1, 8'h30);
        wait_valid("inc3_valid");
        check("inc3_req_cnt", req_q.size() - n0, 32'd2);
        if (req_q.size() >= n0 + 2) begin
            check("inc3_last_addr", {7'd0, req_q[n0 + 1]}, {7'd0, rom_of(16'hFF04)});
        end
        check("inc3_sin", {24'd0, sample_in}, {24'd0, mem(rom_of(16'hFF04))});
        check("inc3_dac", {16'd0, dac_out}, 32'h0000B000);

        // Randomized traffic against the model
        rand_delay = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                logic [1:0] w;
                logic       inc;
                w   = 2'($urandom_range(0, 3));
                inc = 1'($urandom_range(0, 1));
                if (w == 2'b00) inc = 1'b1;
                drive(w, 16'($urandom), inc, 8'($urandom));
            end else begin
                idle(1);
            end
        end
        wait_valid("rand_valid");
        check("rand_addr", {7'd0, bus.rom_addr}, {7'd0, rom_of(model_addr)});
        check("rand_sin", {24'd0, sample_in}, {24'd0, mem(rom_of(model_addr))});
        check("rand_dac", {16'd0, dac_out}, {16'd0, model_dac});

        // Reset with a request outstanding, then a late ack
        idle(3);
        mon_en  = 1'b0;
        resp_en = 1'b0;
        drive(2'b11, 16'h4321, 1'b0, 8'h00);
        k = 0;
        while (!bus.rom_req && k < 20) begin
            idle(1);
            k++;
        end
        check("mid_req_up", {31'd0, bus.rom_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_addr = 16'h0;
        model_dac  = 16'h0;
        check("mid_rst_req", {31'd0, bus.rom_req}, 32'd0);
        check("mid_rst_addr", {7'd0, bus.rom_addr}, {7'd0, BASE});
        check("mid_rst_sin", {24'd0, sample_in}, 32'hFF);
        check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
        check("mid_rst_dac", {16'd0, dac_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        man_ack  = 1'b1;
        man_data = 8'h77;
        idle(1);
        man_ack  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("late_ack_no_req", {31'd0, bus.rom_req}, 32'd0);
            idle(1);
        end
        check("late_ack_sin", {24'd0, sample_in}, 32'hFF);
        check("late_ack_valid", {31'd0, sample_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
